// File: rtl/bargraph_frame_sequencer_if.sv
// Matrix-memory write port shared by the frame sequencer and the host.
// The sequencer (master) receives host write requests and drives the single
// matrix write port; the surrounding system (slave) does the opposite.
interface bargraph_frame_sequencer_if #(
  parameter int ADDR_W = 9
) ();
  logic              host_wr;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [7:0]        host_wr_data;
  logic              host_wr_buf;
  logic              mtrx_wr;
  logic [ADDR_W-1:0] mtrx_wr_addr;
  logic [7:0]        mtrx_wr_data;
  logic              mtrx_wr_buf;

  modport master (
    input  host_wr, host_wr_addr, host_wr_data, host_wr_buf,
    output mtrx_wr, mtrx_wr_addr, mtrx_wr_data, mtrx_wr_buf
  );

  modport slave (
    output host_wr, host_wr_addr, host_wr_data, host_wr_buf,
    input  mtrx_wr, mtrx_wr_addr, mtrx_wr_data, mtrx_wr_buf
  );
endinterface

// File: rtl/bargraph_frame_sequencer.sv
// Bar-graph frame sequencer: on each timebase tick, fills the back buffer
// of the LED matrix memory with one RGB frame, swaps buffers and waits for
// the display engine to confirm the swap. Host writes share the matrix write
// port and always take priority; the fill simply stalls for those cycles.
// Optional peak-hold marker: define BARGRAPH_PEAK_HOLD_EN.
module bargraph_frame_sequencer #(
  parameter int NUM_LEDS   = 30,
  parameter int ADDR_W     = 9,
  parameter int PEAK_DECAY = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [7:0]                 bar_level,
  input  logic [23:0]                on_color,
  input  logic [23:0]                off_color,
  input  logic [23:0]                peak_color,
  input  logic                       tick,
  output logic                       tick_clear,
  bargraph_frame_sequencer_if.master bus,
  output logic                       buffer_select,
  input  logic                       buffer_current,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic                       overrun,
  input  logic                       overrun_clear
);

  localparam int LW = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS * 3 - 1);
  localparam logic [LW-1:0]     NUM_LEDS_L = LW'(NUM_LEDS);

  if (NUM_LEDS < 1 || NUM_LEDS * 3 > 2 ** ADDR_W) begin : g_param_check
    $error("bargraph_frame_sequencer: NUM_LEDS*3 must fit in ADDR_W bits and NUM_LEDS >= 1");
  end

  typedef enum logic [1:0] {IDLE, FILL, SWAP, WAIT_ACK} state_t;

  // Saturate the requested level to the number of LEDs present.
  function automatic logic [LW-1:0] sat_level(input logic [7:0] lv);
    logic [LW-1:0] ext;
    ext = LW'(lv);
    return (ext > NUM_LEDS_L) ? NUM_LEDS_L : ext;
  endfunction

  state_t            state, state_d;
  logic [LW-1:0]     lvl, lvl_d;
  logic [23:0]       on_q, on_d, off_q, off_d;
  logic [LW-1:0]     led_idx, led_idx_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              tick_clear_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_buf_q, wr_buf_d;
  logic              sel_d, busy_d, overrun_d, ovr_set;
  logic [15:0]       fc_d;
  logic [23:0]       cur_color;
  logic [7:0]        cur_byte;

`ifdef BARGRAPH_PEAK_HOLD_EN
  logic [LW-1:0]     peak, peak_d;
  logic [23:0]       peak_q, peak_col_d;
  logic [15:0]       decay_cnt, decay_cnt_d;
`else
  logic              unused_peak;
  assign unused_peak = ^{peak_color, PEAK_DECAY[0]};
`endif

  assign bus.mtrx_wr      = wr_q;
  assign bus.mtrx_wr_addr = wr_addr_q;
  assign bus.mtrx_wr_data = wr_data_q;
  assign bus.mtrx_wr_buf  = wr_buf_q;

  // Pick the colour of the current LED and the byte within it.
  always_comb begin
    cur_color = (led_idx < lvl) ? on_q : off_q;
`ifdef BARGRAPH_PEAK_HOLD_EN
    if (peak != '0 && led_idx == peak - LW'(1)) cur_color = peak_q;
`endif
    case (byte_idx)
      2'd0:    cur_byte = cur_color[23:16];
      2'd1:    cur_byte = cur_color[15:8];
      default: cur_byte = cur_color[7:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d      = state;
    lvl_d        = lvl;
    on_d         = on_q;
    off_d        = off_q;
    led_idx_d    = led_idx;
    byte_idx_d   = byte_idx;
    addr_d       = addr;
    tick_clear_d = 1'b0;
    wr_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_buf_d     = wr_buf_q;
    sel_d        = buffer_select;
    fc_d         = frame_count;
    ovr_set      = 1'b0;
`ifdef BARGRAPH_PEAK_HOLD_EN
    peak_d       = peak;
    peak_col_d   = peak_q;
    decay_cnt_d  = decay_cnt;
`endif
    if (bus.host_wr) begin
      wr_d      = 1'b1;
      wr_addr_d = bus.host_wr_addr;
      wr_data_d = bus.host_wr_data;
      wr_buf_d  = bus.host_wr_buf;
    end
    case (state)
      IDLE: begin
        if (enable && tick) begin
          lvl_d        = sat_level(bar_level);
          on_d         = on_color;
          off_d        = off_color;
          tick_clear_d = 1'b1;
          led_idx_d    = '0;
          byte_idx_d   = '0;
          addr_d       = '0;
          state_d      = FILL;
`ifdef BARGRAPH_PEAK_HOLD_EN
          peak_col_d   = peak_color;
          if (sat_level(bar_level) > peak) peak_d = sat_level(bar_level);
`endif
        end
      end
      FILL: begin
        if (!bus.host_wr) begin
          wr_d      = 1'b1;
          wr_addr_d = addr;
          wr_data_d = cur_byte;
          wr_buf_d  = ~buffer_select;
          if (addr == LAST_ADDR) begin
            state_d = SWAP;
          end else begin
            addr_d = addr + ADDR_W'(1);
            if (byte_idx == 2'd2) begin
              byte_idx_d = 2'd0;
              led_idx_d  = led_idx + LW'(1);
            end else begin
              byte_idx_d = byte_idx + 2'd1;
            end
          end
        end
      end
      SWAP: begin
        sel_d   = ~buffer_select;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (buffer_current == buffer_select) begin
          fc_d    = frame_count + 16'd1;
          state_d = IDLE;
          ovr_set = tick;
`ifdef BARGRAPH_PEAK_HOLD_EN
          if (decay_cnt == 16'(PEAK_DECAY - 1)) begin
            decay_cnt_d = '0;
            if (peak > lvl) peak_d = peak - LW'(1);
          end else begin
            decay_cnt_d = decay_cnt + 16'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    overrun_d = overrun_clear ? 1'b0 : (overrun | ovr_set);
    busy_d    = (state_d != IDLE);
  end

  // Registered outputs, frame parameters and fill counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lvl           <= '0;
      on_q          <= '0;
      off_q         <= '0;
      led_idx       <= '0;
      byte_idx      <= '0;
      addr          <= '0;
      tick_clear    <= 1'b0;
      wr_q          <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_buf_q      <= 1'b0;
      buffer_select <= 1'b0;
      busy          <= 1'b0;
      frame_count   <= '0;
      overrun       <= 1'b0;
`ifdef BARGRAPH_PEAK_HOLD_EN
      peak          <= '0;
      peak_q        <= '0;
      decay_cnt     <= '0;
`endif
    end else begin
      lvl           <= lvl_d;
      on_q          <= on_d;
      off_q         <= off_d;
      led_idx       <= led_idx_d;
      byte_idx      <= byte_idx_d;
      addr          <= addr_d;
      tick_clear    <= tick_clear_d;
      wr_q          <= wr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_buf_q      <= wr_buf_d;
      buffer_select <= sel_d;
      busy          <= busy_d;
      frame_count   <= fc_d;
      overrun       <= overrun_d;
`ifdef BARGRAPH_PEAK_HOLD_EN
      peak          <= peak_d;
      peak_q        <= peak_col_d;
      decay_cnt     <= decay_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bargraph_frame_sequencer.sv
// Directed bench for bargraph_frame_sequencer (default build, 30 LEDs).
`timescale 1ns/1ps
module tb_bargraph_frame_sequencer;
  localparam int NUM_LEDS = 30;
  localparam int ADDR_W   = 9;
  localparam int FRAME    = NUM_LEDS * 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  bar_level = '0;
  logic [23:0] on_color = '0, off_color = '0, peak_color = '0;
  logic        tick = 1'b0;
  logic        tick_clear;
  logic        buffer_select;
  logic        buffer_current = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic        overrun;
  logic        overrun_clear = 1'b0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int tc_cnt = 0;
  int tc_cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              bsel;
    int                cyc;
  } wr_t;
  wr_t wq[$];

  bargraph_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  bargraph_frame_sequencer #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W), .PEAK_DECAY(8)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .bar_level(bar_level),
    .on_color(on_color), .off_color(off_color), .peak_color(peak_color),
    .tick(tick), .tick_clear(tick_clear), .bus(bus),
    .buffer_select(buffer_select), .buffer_current(buffer_current), .busy(busy),
    .frame_count(frame_count), .overrun(overrun), .overrun_clear(overrun_clear)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.mtrx_wr === 1'b1)
      wq.push_back('{bus.mtrx_wr_addr, bus.mtrx_wr_data, bus.mtrx_wr_buf, cyc});
    if (tick_clear === 1'b1) begin
      tc_cnt <= tc_cnt + 1;
      tc_cyc <= cyc;
    end
  end

  function automatic logic [7:0] exp_byte(input int idx, input int lvl,
                                          input logic [23:0] on, input logic [23:0] off);
    logic [23:0] c;
    c = ((idx / 3) < lvl) ? on : off;
    case (idx % 3)
      0:       return c[23:16];
      1:       return c[15:8];
      default: return c[7:0];
    endcase
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic start_frame(output bit ok);
    ok = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick_clear === 1'b1) begin ok = 1'b1; break; end
    end
    tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit follow, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (follow) buffer_current = buffer_select;
      step();
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_swap(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (buffer_select !== buffer_current) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.host_wr = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0; bus.host_wr_buf = 1'b0;
    repeat (3) step();
    checks++; if (bus.mtrx_wr !== 1'b0) $display("FAIL rst_mtrx_wr got %b want 0", bus.mtrx_wr); else passes++;
    checks++; if (bus.mtrx_wr_addr !== '0) $display("FAIL rst_addr got %h want 0", bus.mtrx_wr_addr); else passes++;
    checks++; if (tick_clear !== 1'b0) $display("FAIL rst_tick_clear got %b want 0", tick_clear); else passes++;
    checks++; if (buffer_select !== 1'b0) $display("FAIL rst_buffer_select got %b want 0", buffer_select); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
    checks++; if (frame_count !== 16'd0) $display("FAIL rst_frame_count got %0d want 0", frame_count); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", overrun); else passes++;
    resetn = 1'b1;
    enable = 1'b1;
    step();
  endtask

  task automatic test_basic_frame();
    bit ok;
    int tc0, tcc;
    wq.delete();
    tc0 = tc_cnt;
    bar_level = 8'd10; on_color = 24'hFF0000; off_color = 24'h000010;
    start_frame(ok);
    tcc = tc_cyc;
    checks++; if (ok !== 1'b1) $display("FAIL basic_start got %b want 1", ok); else passes++;
    wait_idle(300, 1'b1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL basic_done got %b want 1", ok); else passes++;
    checks++; if (tc_cnt - tc0 !== 1) $display("FAIL basic_tick_clear_cycles got %0d want 1", tc_cnt - tc0); else passes++;
    checks++; if (wq.size() !== FRAME) $display("FAIL basic_writes got %0d want %0d", wq.size(), FRAME); else passes++;
    for (int i = 0; i < wq.size() && i < FRAME; i++) begin
      checks++; if (wq[i].addr !== ADDR_W'(i)) $display("FAIL basic_addr[%0d] got %0d want %0d", i, wq[i].addr, i); else passes++;
      checks++; if (wq[i].data !== exp_byte(i, 10, 24'hFF0000, 24'h000010))
        $display("FAIL basic_data[%0d] got %h want %h", i, wq[i].data, exp_byte(i, 10, 24'hFF0000, 24'h000010)); else passes++;
      checks++; if (wq[i].bsel !== 1'b1) $display("FAIL basic_buf[%0d] got %b want 1", i, wq[i].bsel); else passes++;
    end
    if (wq.size() == FRAME) begin
      checks++; if (wq[0].cyc !== tcc + 1) $display("FAIL basic_first_latency got %0d want %0d", wq[0].cyc, tcc + 1); else passes++;
      checks++; if (wq[FRAME-1].cyc - wq[0].cyc !== FRAME - 1)
        $display("FAIL basic_contiguous got %0d want %0d", wq[FRAME-1].cyc - wq[0].cyc, FRAME - 1); else passes++;
    end
    checks++; if (buffer_select !== 1'b1) $display("FAIL basic_buffer_select got %b want 1", buffer_select); else passes++;
    checks++; if (frame_count !== 16'd1) $display("FAIL basic_frame_count got %0d want 1", frame_count); else passes++;
  endtask

  task automatic test_clamp();
    bit ok;
    int maxa;
    wq.delete();
    maxa = 0;
    bar_level = 8'd200; on_color = 24'h123456; off_color = 24'hABCDEF;
    start_frame(ok);
    wait_idle(300, 1'b1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL clamp_done got %b want 1", ok); else passes++;
    checks++; if (wq.size() !== FRAME) $display("FAIL clamp_writes got %0d want %0d", wq.size(), FRAME); else passes++;
    for (int i = 0; i < wq.size(); i++) begin
      if (int'(wq[i].addr) > maxa) maxa = int'(wq[i].addr);
      if (i < FRAME) begin
        checks++; if (wq[i].data !== exp_byte(i, NUM_LEDS, 24'h123456, 24'hABCDEF))
          $display("FAIL clamp_data[%0d] got %h want %h", i, wq[i].data, exp_byte(i, NUM_LEDS, 24'h123456, 24'hABCDEF)); else passes++;
        checks++; if (wq[i].bsel !== 1'b0) $display("FAIL clamp_buf[%0d] got %b want 0", i, wq[i].bsel); else passes++;
      end
    end
    checks++; if (maxa !== FRAME - 1) $display("FAIL clamp_max_addr got %0d want %0d", maxa, FRAME - 1); else passes++;
    checks++; if (frame_count !== 16'd2) $display("FAIL clamp_frame_count got %0d want 2", frame_count); else passes++;
  endtask

  task automatic test_host_arb();
    bit ok;
    int hc[5];
    int nh, ns;
    logic [7:0] kk;
    wq.delete();
    bar_level = 8'd5; on_color = 24'h00FF00; off_color = 24'h0000FF;
    start_frame(ok);
    repeat (20) step();
    for (int k = 0; k < 5; k++) begin
      kk = 8'(k);
      bus.host_wr = 1'b1;
      bus.host_wr_addr = ADDR_W'(9'h1F0 + k);
      bus.host_wr_data = 8'hA0 + kk;
      bus.host_wr_buf = kk[0];
      hc[k] = cyc;
      step();
    end
    bus.host_wr = 1'b0;
    wait_idle(300, 1'b1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL host_done got %b want 1", ok); else passes++;
    checks++; if (wq.size() !== FRAME + 5) $display("FAIL host_total got %0d want %0d", wq.size(), FRAME + 5); else passes++;
    nh = 0; ns = 0;
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i].addr >= ADDR_W'(9'h1F0)) begin
        if (nh < 5) begin
          kk = 8'(nh);
          checks++; if (wq[i].addr !== ADDR_W'(9'h1F0 + nh)) $display("FAIL host_addr[%0d] got %h want %h", nh, wq[i].addr, 9'h1F0 + nh); else passes++;
          checks++; if (wq[i].data !== 8'hA0 + kk) $display("FAIL host_data[%0d] got %h want %h", nh, wq[i].data, 8'hA0 + kk); else passes++;
          checks++; if (wq[i].bsel !== kk[0]) $display("FAIL host_buf[%0d] got %b want %b", nh, wq[i].bsel, kk[0]); else passes++;
          checks++; if (wq[i].cyc !== hc[nh] + 1) $display("FAIL host_latency[%0d] got %0d want %0d", nh, wq[i].cyc, hc[nh] + 1); else passes++;
        end
        nh++;
      end else begin
        if (ns < FRAME) begin
          checks++; if (wq[i].addr !== ADDR_W'(ns)) $display("FAIL host_seq_addr[%0d] got %0d want %0d", ns, wq[i].addr, ns); else passes++;
          checks++; if (wq[i].data !== exp_byte(ns, 5, 24'h00FF00, 24'h0000FF))
            $display("FAIL host_seq_data[%0d] got %h want %h", ns, wq[i].data, exp_byte(ns, 5, 24'h00FF00, 24'h0000FF)); else passes++;
          checks++; if (wq[i].bsel !== 1'b1) $display("FAIL host_seq_buf[%0d] got %b want 1", ns, wq[i].bsel); else passes++;
        end
        ns++;
      end
    end
    checks++; if (nh !== 5) $display("FAIL host_count got %0d want 5", nh); else passes++;
    checks++; if (ns !== FRAME) $display("FAIL host_seq_count got %0d want %0d", ns, FRAME); else passes++;
    if (wq.size() == FRAME + 5) begin
      checks++; if (wq[FRAME+4].cyc - wq[0].cyc !== FRAME + 4)
        $display("FAIL host_contiguous got %0d want %0d", wq[FRAME+4].cyc - wq[0].cyc, FRAME + 4); else passes++;
    end
  endtask

  task automatic test_wait_ack();
    bit ok;
    int held;
    logic [15:0] fc0;
    bar_level = 8'd0;
    start_frame(ok);
    wait_swap(ok);
    checks++; if (ok !== 1'b1) $display("FAIL ack_swap got %b want 1", ok); else passes++;
    fc0 = frame_count;
    held = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy === 1'b1) held++;
    end
    checks++; if (held !== 100) $display("FAIL ack_busy_held got %0d want 100", held); else passes++;
    checks++; if (frame_count !== fc0) $display("FAIL ack_fc_held got %0d want %0d", frame_count, fc0); else passes++;
    buffer_current = buffer_select;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL ack_busy_release got %b want 0", busy); else passes++;
    checks++; if (frame_count !== fc0 + 16'd1) $display("FAIL ack_fc_inc got %0d want %0d", frame_count, fc0 + 16'd1); else passes++;
  endtask

  task automatic test_overrun();
    bit ok;
    logic [15:0] fc0;
    bar_level = 8'd3;
    start_frame(ok);
    wait_swap(ok);
    fc0 = frame_count;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_initial got %b want 0", overrun); else passes++;
    buffer_current = buffer_select;
    tick = 1'b1;
    step();
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else passes++;
    checks++; if (frame_count !== fc0 + 16'd1) $display("FAIL ovr_fc got %0d want %0d", frame_count, fc0 + 16'd1); else passes++;
    step();
    checks++; if (tick_clear !== 1'b1) $display("FAIL ovr_pending_tick got %b want 1", tick_clear); else passes++;
    tick = 1'b0;
    wait_swap(ok);
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun); else passes++;
    buffer_current = buffer_select;
    tick = 1'b1;
    overrun_clear = 1'b1;
    enable = 1'b0;
    step();
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear_wins got %b want 0", overrun); else passes++;
    overrun_clear = 1'b0;
    tick = 1'b0;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL ovr_no_start got %b want 0", busy); else passes++;
    enable = 1'b1;
  endtask

  task automatic test_enable_midframe();
    bit ok;
    int tc0;
    logic [15:0] fc0;
    wq.delete();
    tc0 = tc_cnt;
    fc0 = frame_count;
    bar_level = 8'd7;
    start_frame(ok);
    repeat (10) step();
    enable = 1'b0;
    tick = 1'b1;
    wait_idle(300, 1'b1, ok);
    checks++; if (wq.size() !== FRAME) $display("FAIL en_frame_completes got %0d want %0d", wq.size(), FRAME); else passes++;
    checks++; if (frame_count !== fc0 + 16'd1) $display("FAIL en_fc got %0d want %0d", frame_count, fc0 + 16'd1); else passes++;
    repeat (20) step();
    checks++; if (busy !== 1'b0) $display("FAIL en_stays_idle got %b want 0", busy); else passes++;
    checks++; if (tc_cnt - tc0 !== 1) $display("FAIL en_no_retrigger got %0d want 1", tc_cnt - tc0); else passes++;
    enable = 1'b1;
    step();
    checks++; if (tick_clear !== 1'b1) $display("FAIL en_resume got %b want 1", tick_clear); else passes++;
    tick = 1'b0;
    wait_idle(300, 1'b1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL en_resume_done got %b want 1", ok); else passes++;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bar_level = 8'd10; on_color = 24'hFF0000; off_color = 24'h000010;
    wq.delete();
    start_frame(ok);
    for (int i = 0; i < 200 && wq.size() < 40; i++) step();
    checks++; if (wq.size() < 40) $display("FAIL mid_reach40 got %0d want 40", wq.size()); else passes++;
    resetn = 1'b0;
    #1;
    checks++; if (bus.mtrx_wr !== 1'b0) $display("FAIL mid_mtrx_wr got %b want 0", bus.mtrx_wr); else passes++;
    checks++; if (bus.mtrx_wr_addr !== '0) $display("FAIL mid_addr got %h want 0", bus.mtrx_wr_addr); else passes++;
    checks++; if (bus.mtrx_wr_data !== 8'h00) $display("FAIL mid_data got %h want 0", bus.mtrx_wr_data); else passes++;
    checks++; if (bus.mtrx_wr_buf !== 1'b0) $display("FAIL mid_buf got %b want 0", bus.mtrx_wr_buf); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else passes++;
    checks++; if (frame_count !== 16'd0) $display("FAIL mid_frame_count got %0d want 0", frame_count); else passes++;
    checks++; if (buffer_select !== 1'b0) $display("FAIL mid_buffer_select got %b want 0", buffer_select); else passes++;
    step();
    resetn = 1'b1;
    buffer_current = 1'b0;
    step();
    wq.delete();
    start_frame(ok);
    wait_idle(300, 1'b1, ok);
    checks++; if (wq.size() !== FRAME) $display("FAIL mid_restart_writes got %0d want %0d", wq.size(), FRAME); else passes++;
    if (wq.size() > 0) begin
      checks++; if (wq[0].addr !== '0) $display("FAIL mid_restart_addr got %0d want 0", wq[0].addr); else passes++;
      checks++; if (wq[0].bsel !== 1'b1) $display("FAIL mid_restart_buf got %b want 1", wq[0].bsel); else passes++;
    end
    checks++; if (frame_count !== 16'd1) $display("FAIL mid_restart_fc got %0d want 1", frame_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_clamp();
    test_host_arb();
    test_wait_ack();
    test_overrun();
    test_enable_midframe();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bargraph_frame_sequencer.md
Name: bargraph_frame_sequencer

Overview:
- Autonomous frame builder for the RGB LED bar-graph matrix memory.
- On each timebase tick it writes a full RGB frame into the back buffer, swaps display buffers, then waits for the display side to confirm the swap.
- Shares the single matrix-memory write port with host (Avalon slave) writes. Host writes always win.
- Sits between the Avalon register slave, the timebase and the matrix memory/display engine.

Parameters:
- NUM_LEDS, 30, number of RGB LEDs; frame length = NUM_LEDS*3 bytes; must be >=1.
- ADDR_W, 9, matrix write address width; NUM_LEDS*3 <= 2**ADDR_W (elaboration-time check).
- PEAK_DECAY, 8, frames between peak-hold decrements (optional feature only).

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- enable  in  1  allow new frames to start
- bar_level  in  8  requested lit LED count
- on_color  in  24  lit colour {R,G,B}
- off_color  in  24  unlit colour {R,G,B}
- peak_color  in  24  peak marker colour (used only with the optional feature)
- tick  in  1  timebase flag, level, sticky
- tick_clear  out  1  one-cycle clear pulse to the timebase
- host_wr  in  1  host write strobe
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  8  host write data
- host_wr_buf  in  1  host target buffer
- mtrx_wr  out  1  matrix write strobe
- mtrx_wr_addr  out  ADDR_W  matrix write address
- mtrx_wr_data  out  8  matrix write data
- mtrx_wr_buf  out  1  buffer written
- buffer_select  out  1  front buffer request
- buffer_current  in  1  front buffer actually displayed
- busy  out  1  high whenever state != IDLE
- frame_count  out  16  completed frames, wraps at 16'hFFFF->0
- overrun  out  1  sticky late flag
- overrun_clear  in  1  clears overrun

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- All outputs are registered.
- States: IDLE, FILL, SWAP, WAIT_ACK.
- IDLE:
  - When enable && tick: latch lvl = min(bar_level, NUM_LEDS) and all three colours.
  - Drive tick_clear=1 for exactly one cycle; zero led_idx/byte_idx; go to FILL.
- FILL:
  - Each cycle with host_wr=0: emit one write the next cycle.
  - Write fields: mtrx_wr_addr = led_idx*3+byte_idx; mtrx_wr_buf = ~buffer_select.
  - Data byte: byte0 = colour[23:16], byte1 = [15:8], byte2 = [7:0].
  - Colour selection: on_color if led_idx < lvl, else off_color.
  - byte_idx wraps 2->0 and increments led_idx.
  - After address NUM_LEDS*3-1 is emitted, go to SWAP.
- Arbitration:
  - Any cycle with host_wr=1 (in any state): the next cycle forwards host_wr_addr/data/buf with mtrx_wr=1.
  - The sequencer holds its counters that cycle; no byte is lost or duplicated.
  - Latency is 1 cycle for both sources.
- SWAP: toggle buffer_select; go to WAIT_ACK.
- WAIT_ACK:
  - Stay until buffer_current == buffer_select.
  - Then increment frame_count, go to IDLE.
  - If tick=1 in that same cycle, set overrun.
- overrun_clear has priority over a simultaneous overrun set (clear wins).
- Deasserting enable mid-frame: the current frame completes; no new frame starts.
- tick is ignored outside IDLE. It stays pending and is serviced on return to IDLE.
- Minimum frame is NUM_LEDS*3+3 cycles. The one-cycle tick_clear latency of the timebase therefore never re-triggers a frame.
- Asynchronous reset mid-frame: immediate return to reset values; a partially written back buffer is left as is.

Optional Feature:
- Macro: BARGRAPH_PEAK_HOLD_EN.
- Defined:
  - An internal peak register tracks max(peak, lvl) at each frame start.
  - Peak decrements by 1 every PEAK_DECAY completed frames, not below lvl.
  - If peak>0, LED index peak-1 uses peak_color; this overrides on_color.
  - Peak resets to 0.
- Undefined: no peak logic; peak_color is ignored; colours as above.

Test Plan:
- NUM_LEDS=30, bar_level=10, on=0xFF0000, off=0x000010, tick pulse -> tick_clear for 1 cycle, then 90 writes to addr 0..89 with mtrx_wr_buf=1. Data: LEDs 0-9 give FF,00,00; LEDs 10-29 give 00,00,10. buffer_select goes 0->1.
- bar_level=200 -> all 30 LEDs on_color (clamp); address never exceeds 89.
- host_wr asserted for 5 cycles during FILL -> 5 host writes forwarded verbatim, frame still exactly 90 sequencer writes, total 95 strobes, no gaps or duplicates.
- buffer_current held at 0 for 100 cycles after swap -> busy stays 1 and frame_count is unchanged. Releasing it -> frame_count +1, busy=0 next cycle.
- tick high on the WAIT_ACK exit cycle -> overrun=1. Assert overrun_clear and set simultaneously -> overrun=0.
- resetn low at byte 40 of FILL -> all outputs 0 immediately. The next tick starts again at address 0 with mtrx_wr_buf=1.
